icache_nway: RTL and testbench

- Parametrised N-way set-associative, read-only instruction cache. Successor to the fixed 2-way icache datapath/control pair.
- Tag, valid, data and tree-PLRU state live in a single block, together with its own fill FSM.
- Sits between the fetch stage (CPU side, 256-bit line interface via the bus adapter) and the arbiter/physical memory.
- Adds flush (fence.i) support, invalid-way-first victim selection and tree pseudo-LRU for any power-of-two way count.

---
 rtl/icache_nway.sv | 245 ++++++++++++++++++++++++
 tb/tb_icache_nway.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with tree-PLRU replacement,
// fill FSM and fence.i flush. Define ICACHE_PERF_CNT_EN to add hit/miss counters.
module icache_nway #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int num_ways = 4,
    parameter int s_tag    = 32 - s_offset - s_index,
    parameter int s_line   = 8 * (2 ** s_offset)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic [31:0]       mem_address,
    output logic [s_line-1:0] mem_rdata256,
    output logic              mem_resp,
    input  logic              flush,
    output logic              flush_done,
    output logic              pmem_read,
    output logic [31:0]       pmem_address,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int num_sets = 2 ** s_index;
    localparam int s_way    = $clog2(num_ways);

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t r_state;
    state_t w_next_state;

    logic [s_line-1:0]   r_data  [num_ways][num_sets];
    logic [s_tag-1:0]    r_tag   [num_ways][num_sets];
    logic [num_sets-1:0] r_valid [num_ways];
    // Heap-ordered tree: node 1 is the root, children of n are 2n and 2n+1.
    logic [num_ways-1:1] r_plru  [num_sets];

    logic [s_way-1:0]    r_victim;
    logic                r_flush_pending;
    logic                r_flush_done;

    logic [s_index-1:0]  w_index;
    logic [s_tag-1:0]    w_addr_tag;
    logic [num_ways-1:0] w_hit;
    logic                w_any_hit;
    logic [s_way-1:0]    w_hit_way;
    logic                w_has_invalid;
    logic [s_way-1:0]    w_first_invalid;
    logic [s_way-1:0]    w_plru_victim;
    logic                w_plru_we;
    logic [s_way-1:0]    w_plru_way;
    logic                w_fill_we;
    logic                w_latch_victim;
    logic                w_flush_exec;
    logic                w_flush_set;
    logic                w_unused;

    assign w_index    = mem_address[s_offset +: s_index];
    assign w_addr_tag = mem_address[31 -: s_tag];
    assign w_unused   = ^mem_address[s_offset-1:0];
    assign flush_done = r_flush_done;

    // Walking the path from the root, each node is made to point away from the accessed way.
    function automatic logic [num_ways-1:1] plru_touch(
        input logic [num_ways-1:1] bits,
        input logic [s_way-1:0]    way
    );
        logic [s_way-1:0] node;
        plru_touch = bits;
        node       = s_way'(1);
        for (int l = 0; l < s_way; l++) begin
            plru_touch[node] = ~way[s_way-1-l];
            node = (node << 1) | s_way'(way[s_way-1-l]);
        end
    endfunction

    always_comb begin
        w_hit = '0;
        for (int w = 0; w < num_ways; w++) begin
            w_hit[w] = mem_read & r_valid[w][w_index] & (r_tag[w][w_index] == w_addr_tag);
        end
    end

    assign w_any_hit = |w_hit;

    always_comb begin
        w_hit_way = '0;
        for (int w = 0; w < num_ways; w++) begin
            if (w_hit[w]) begin
                w_hit_way = s_way'(w);
            end
        end
    end

    always_comb begin
        w_has_invalid   = 1'b0;
        w_first_invalid = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (!r_valid[w][w_index]) begin
                w_has_invalid   = 1'b1;
                w_first_invalid = s_way'(w);
            end
        end
    end

    always_comb begin
        logic [s_way-1:0] node;
        w_plru_victim = '0;
        node          = s_way'(1);
        for (int l = 0; l < s_way; l++) begin
            w_plru_victim[s_way-1-l] = r_plru[w_index][node];
            node = (node << 1) | s_way'(w_plru_victim[s_way-1-l]);
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_next_state   = r_state;
        mem_resp       = 1'b0;
        mem_rdata256   = '0;
        pmem_read      = 1'b0;
        pmem_address   = '0;
        w_plru_we      = 1'b0;
        w_plru_way     = '0;
        w_fill_we      = 1'b0;
        w_latch_victim = 1'b0;
        w_flush_exec   = 1'b0;
        w_flush_set    = 1'b0;
        unique case (r_state)
            IDLE: begin
                // A deferred flush owns the first free IDLE cycle; a held request waits one cycle.
                if (r_flush_pending) begin
                    w_flush_exec = 1'b1;
                end else if (mem_read) begin
                    w_flush_set = flush;
                    if (w_any_hit) begin
                        mem_resp     = 1'b1;
                        mem_rdata256 = r_data[w_hit_way][w_index];
                        w_plru_we    = 1'b1;
                        w_plru_way   = w_hit_way;
                    end else begin
                        w_latch_victim = 1'b1;
                        w_next_state   = FILL;
                    end
                end else if (flush) begin
                    w_flush_exec = 1'b1;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[31:s_offset], {s_offset{1'b0}}};
                w_flush_set  = flush;
                if (pmem_resp) begin
                    w_fill_we    = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                mem_resp     = 1'b1;
                mem_rdata256 = r_data[r_victim][w_index];
                w_plru_we    = 1'b1;
                w_plru_way   = r_victim;
                w_flush_set  = flush;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_victim        <= '0;
            r_flush_pending <= 1'b0;
            r_flush_done    <= 1'b0;
            for (int w = 0; w < num_ways; w++) begin
                r_valid[w] <= '0;
            end
            for (int s = 0; s < num_sets; s++) begin
                r_plru[s] <= '0;
            end
        end else begin
            r_state      <= w_next_state;
            r_flush_done <= w_flush_exec;
            if (w_flush_exec) begin
                r_flush_pending <= 1'b0;
            end else if (w_flush_set) begin
                r_flush_pending <= 1'b1;
            end
            if (w_latch_victim) begin
                r_victim <= w_has_invalid ? w_first_invalid : w_plru_victim;
            end
            if (w_plru_we) begin
                r_plru[w_index] <= plru_touch(r_plru[w_index], w_plru_way);
            end
            if (w_flush_exec) begin
                for (int w = 0; w < num_ways; w++) begin
                    r_valid[w] <= '0;
                end
            end else if (w_fill_we) begin
                r_valid[r_victim][w_index] <= 1'b1;
            end
        end
    end

    // NOTE: tag and data arrays have no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[r_victim][w_index] <= pmem_rdata;
            r_tag[r_victim][w_index]  <= w_addr_tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (r_state == IDLE && mem_resp) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (r_state == IDLE && w_next_state == FILL) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

    a_onehot_hit: assert property (@(posedge clk) disable iff (rst) $onehot0(w_hit));
    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        (mem_read && !mem_resp) |=> (mem_read && $stable(mem_address)));

endmodule

// File: tb/tb_icache_nway.sv
// Randomised scoreboard bench for icache_nway: a range-based tree-PLRU cache model
// predicts hit/miss and line data; a monitor checks every response and fill request.
module tb_icache_nway #(
    parameter int NUM_WAYS = 4
);
    localparam int S_OFFSET = 5;
    localparam int S_INDEX  = 3;
    localparam int NUM_SETS = 1 << S_INDEX;
    localparam int S_LINE   = 8 << S_OFFSET;

    typedef struct {
        logic [31:0]       addr;
        logic [S_LINE-1:0] data;
        bit                hit;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_read;
    logic [31:0]       mem_address;
    logic [S_LINE-1:0] mem_rdata256;
    logic              mem_resp;
    logic              flush;
    logic              flush_done;
    logic              pmem_read;
    logic [31:0]       pmem_address;
    logic [S_LINE-1:0] pmem_rdata;
    logic              pmem_resp;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif

    icache_nway #(.num_ways(NUM_WAYS)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_rdata256 (mem_rdata256),
        .mem_resp     (mem_resp),
        .flush        (flush),
        .flush_done   (flush_done),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    exp_t        sb[$];
    logic [31:0] drv_addr      = '0;
    int          req_cyc       = 0;
    int          last_pmem_cyc = -10;
    bit          addr_checked  = 1'b1;
    int          pmem_lat      = 3;
    bit          pmem_auto     = 1'b1;

    // Reference model: per-set valid/tag table plus one PLRU bit per subtree range.
    bit          m_valid [NUM_SETS][NUM_WAYS];
    logic [31:0] m_tag   [NUM_SETS][NUM_WAYS];
    bit          m_node  [NUM_SETS][256];
    int          m_hits   = 0;
    int          m_misses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_line(input string name, input logic [S_LINE-1:0] act, input logic [S_LINE-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [S_LINE-1:0] line_of(input logic [31:0] a);
        logic [31:0]       la;
        logic [S_LINE-1:0] r;
        la = a >> S_OFFSET;
        for (int k = 0; k < S_LINE / 32; k++) begin
            r[k*32 +: 32] = (la * 32'h9E3779B1) ^ (32'(k) * 32'h01234567) ^ la;
        end
        return r;
    endfunction

    function automatic int node_key(input int lo, input int hi);
        return lo * 16 + (hi - lo);
    endfunction

    function automatic int model_victim(input int s);
        int lo, hi, mid;
        lo = 0;
        hi = NUM_WAYS;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (m_node[s][node_key(lo, hi)]) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    function automatic void model_touch(input int s, input int w);
        int lo, hi, mid;
        lo = 0;
        hi = NUM_WAYS;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w < mid) begin
                m_node[s][node_key(lo, hi)] = 1'b1;
                hi = mid;
            end else begin
                m_node[s][node_key(lo, hi)] = 1'b0;
                lo = mid;
            end
        end
    endfunction

    task automatic model_access(input logic [31:0] a, output bit hit);
        int          s;
        int          way;
        logic [31:0] t;
        s   = int'((a >> S_OFFSET) & (NUM_SETS - 1));
        t   = a >> (S_OFFSET + S_INDEX);
        hit = 1'b0;
        way = -1;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                hit = 1'b1;
                way = w;
            end
        end
        if (hit) begin
            m_hits++;
        end else begin
            m_misses++;
            for (int w = NUM_WAYS - 1; w >= 0; w--) begin
                if (!m_valid[s][w]) way = w;
            end
            if (way < 0) way = model_victim(s);
            m_valid[s][way] = 1'b1;
            m_tag[s][way]   = t;
        end
        model_touch(s, way);
    endtask

    task automatic model_flush();
        for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++) m_valid[s][w] = 1'b0;
    endtask

    task automatic model_reset();
        model_flush();
        for (int s = 0; s < NUM_SETS; s++)
            for (int n = 0; n < 256; n++) m_node[s][n] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Physical memory: answers a fill after pmem_lat cycles of pmem_read.
    initial begin
        int cnt;
        cnt        = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!pmem_auto) begin
                cnt = 0;
                continue;
            end
            pmem_resp = 1'b0;
            if (pmem_read) begin
                cnt++;
                if (cnt >= pmem_lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = line_of(pmem_address);
                    cnt        = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: checks fill addresses and pops the scoreboard on every response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pmem_read) begin
                if (pmem_resp) last_pmem_cyc = cyc;
                if (!addr_checked) begin
                    check("pmem_address", pmem_address, {drv_addr[31:S_OFFSET], {S_OFFSET{1'b0}}});
                    addr_checked = 1'b1;
                end
            end
            if (mem_resp) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got mem_resp=1 expected no response (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check_line("rdata", mem_rdata256, e.data);
                    if (e.hit) check("hit_latency_cycle", cyc, req_cyc);
                    else       check("miss_resp_cycle", cyc, last_pmem_cyc + 1);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a);
        @(posedge clk);
        #1;
        drv_addr     = a;
        addr_checked = 1'b0;
        mem_read     = 1'b1;
        mem_address  = a;
        req_cyc      = cyc;
    endtask

    // flush_at: -1 none, 0 together with the request, k>0 pulsed k cycles later.
    task automatic do_read(input logic [31:0] a, input int flush_at);
        exp_t e;
        bit   hit;
        bit   got;
        model_access(a, hit);
        e.addr = a;
        e.data = line_of(a);
        e.hit  = hit;
        sb.push_back(e);
        issue(a);
        flush = (flush_at == 0);
        got   = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (mem_resp) got = 1'b1;
            @(posedge clk);
            #1;
            flush = (flush_at == n + 1) && !got;
        end
        mem_read = 1'b0;
        flush    = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got no mem_resp expected one for %h", a);
            void'(sb.pop_front());
        end
    endtask

    // Entered at posedge+1 of the cycle in which the invalidate executes.
    task automatic expect_flush_seq();
        @(negedge clk);
        check("flush_done_early", {31'b0, flush_done}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_done_pulse", {31'b0, flush_done}, 32'd1);
        @(negedge clk);
        check("flush_done_clear", {31'b0, flush_done}, 32'd0);
        model_flush();
    endtask

    task automatic do_flush();
        @(posedge clk);
        #1;
        flush = 1'b1;
        expect_flush_seq();
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

`ifdef ICACHE_PERF_CNT_EN
    task automatic check_counters(input string tag);
        @(negedge clk);
        check({tag, "_hit_count"}, hit_count, 32'(m_hits));
        check({tag, "_miss_count"}, miss_count, 32'(m_misses));
    endtask
`endif

    initial begin
        logic [31:0] a;
        rst         = 1'b1;
        mem_read    = 1'b0;
        mem_address = '0;
        flush       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_mem_resp", {31'b0, mem_resp}, 32'd0);
        check("rst_pmem_read", {31'b0, pmem_read}, 32'd0);
        check("rst_flush_done", {31'b0, flush_done}, 32'd0);
        check("rst_pmem_address", pmem_address, 32'd0);
        check_line("rst_rdata", mem_rdata256, '0);

        // Cold miss, then a hit on the same line.
        pmem_lat = 3;
        do_read(32'h0000_0040, -1);
        do_read(32'h0000_0044, -1);

        // Four lines in set 2, a PLRU hit, then an eviction.
        do_read(32'h0000_0140, -1);
        do_read(32'h0000_0240, -1);
        do_read(32'h0000_0340, -1);
        do_read(32'h0000_0040, -1);
        do_read(32'h0000_0440, -1);
        do_read(32'h0000_0040, -1);
        do_read(32'h0000_0248, -1);
        do_read(32'h0000_0140, -1);

        // Flush during a fill: response still delivered, invalidate afterwards.
        do_read(32'h1000_0000, 2);
        expect_flush_seq();
        do_read(32'h1000_0000, -1);

        // Idle flush, then flush together with a hit.
        do_flush();
        do_read(32'h0000_0040, -1);
        do_read(32'h0000_0040, 0);
        expect_flush_seq();
        do_read(32'h0000_0040, -1);

        // Reset in the middle of a fill with a flush pending.
        pmem_auto = 1'b0;
        issue(32'h2000_0040);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("pmem_read_before_rst", {31'b0, pmem_read}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_read = 1'b0;
        model_reset();
        @(negedge clk);
        check("pmem_read_after_rst", {31'b0, pmem_read}, 32'd0);
        @(posedge clk);
        #1;
        pmem_resp  = 1'b1;
        pmem_rdata = ~line_of(32'h2000_0040);
        @(negedge clk);
        check("stray_pmem_resp", {31'b0, mem_resp}, 32'd0);
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        pmem_auto = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_flush_after_rst", {31'b0, flush_done}, 32'd0);
        end
`ifdef ICACHE_PERF_CNT_EN
        check_counters("after_rst");
`endif
        do_read(32'h2000_0040, -1);
        do_read(32'h0000_0040, -1);

        // Random addresses in two sets with a small tag pool to force evictions.
        for (int i = 0; i < 100; i++) begin
            int t;
            t        = $urandom_range(0, NUM_WAYS + 1);
            pmem_lat = $urandom_range(1, 4);
            a = (32'(t) * 32'h0000_1001) << (S_OFFSET + S_INDEX);
            a = a | (32'($urandom_range(0, 1)) << S_OFFSET) | (32'($urandom_range(0, 7)) << 2);
            do_read(a, -1);
            if ($urandom_range(0, 15) == 0) do_flush();
        end

        // Counter scenario: 5 misses and 12 hits, then flush and reset.
        pulse_reset();
        pmem_lat = 2;
        for (int i = 0; i < 5; i++) do_read(32'(i) << S_OFFSET, -1);
        for (int i = 0; i < 12; i++) do_read((32'(i % 5) << S_OFFSET) | 32'h4, -1);
`ifdef ICACHE_PERF_CNT_EN
        check_counters("after_traffic");
        check("miss_count_is_5", miss_count, 32'd5);
        check("hit_count_is_12", hit_count, 32'd12);
        do_flush();
        check_counters("after_flush");
        pulse_reset();
        check_counters("after_final_rst");
`endif
        do_read(32'h0000_0000, -1);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
